// File: rtl/io_ram_banker_if.sv
// Expansion-bus side of the IO-page RAM banker: CPU cycle qualifiers in,
// SRAM address/strobes out. The two bidirectional data buses are carried
// as plain top-level inout ports so tristate resolution stays at the module
// boundary.
interface io_ram_banker_if #(
  parameter int MEM_AW = 19
);
  logic              r_w_cpu;
  logic [2:1]        _io;
  logic [15:0]       address_cpu;
  logic              _enbus;
  logic [MEM_AW-1:0] address_mem;
  logic              _we_mem;
  logic              _ce_ram;

  // CPU / cartridge-bus side
  modport master (
    output r_w_cpu, _io, address_cpu,
    input  _enbus, address_mem, _we_mem, _ce_ram
  );

  // banker side
  modport slave (
    input  r_w_cpu, _io, address_cpu,
    output _enbus, address_mem, _we_mem, _ce_ram
  );
endinterface

// File: rtl/io_ram_banker.sv
// IO1 page mapped onto SRAM through a bank register; IO2 page holds a small
// register file plus a pointer-based SRAM data port with auto-increment.
// All decode and steering is combinational; state changes at the rising
// clock_cpu edge that closes the bus cycle.
module io_ram_banker #(
  parameter int         MEM_AW   = 19,
  parameter int         WIN_AW   = 8,
  parameter logic [7:0] ID_VALUE = 8'h54
) (
  input  logic            clock_cpu,
  input  logic            _reset_cpu,
  io_ram_banker_if.slave  bus,
  inout  wire  [7:0]      data_cpu,
  inout  wire  [7:0]      data_mem
);

  localparam int BW = MEM_AW - WIN_AW;

  localparam logic [2:0] R_BANK_LO = 3'd0;
  localparam logic [2:0] R_BANK_HI = 3'd1;
  localparam logic [2:0] R_PTR_L   = 3'd2;
  localparam logic [2:0] R_PTR_M   = 3'd3;
  localparam logic [2:0] R_PTR_H   = 3'd4;
  localparam logic [2:0] R_DATA    = 3'd5;
  localparam logic [2:0] R_CTRL    = 3'd6;
  localparam logic [2:0] R_ID      = 3'd7;

  logic [BW-1:0]     bank;
  logic [MEM_AW-1:0] ptr;
  logic              win_en;
  logic              ainc;

  logic        io1, io2, data_sel, reg_wr, ce;
  logic [2:0]  rsel;
  logic [23:0] bank_ext, ptr_ext, bank_nxt, ptr_nxt;
  logic [7:0]  reg_rd, cpu_out;
  logic        cpu_oe, mem_oe;

  // Registers are viewed as 24-bit zero-extended values so byte lanes above
  // the implemented width read 0 and absorb writes harmlessly.
  assign bank_ext = 24'(bank);
  assign ptr_ext  = 24'(ptr);

  // Cycle decode: IO1 has priority when both selects are asserted.
  always_comb begin
    io1      = ~bus._io[1];
    io2      = bus._io[1] & ~bus._io[2];
    rsel     = bus.address_cpu[2:0];
    data_sel = io2 & (rsel == R_DATA);
    reg_wr   = io2 & ~bus.r_w_cpu;
    ce       = (io1 & win_en) | data_sel;
  end

  // Register read-back mux (DATA is served from SRAM, not from here).
  always_comb begin
    reg_rd = 8'h00;
    case (rsel)
      R_BANK_LO: reg_rd = bank_ext[7:0];
      R_BANK_HI: reg_rd = bank_ext[15:8];
      R_PTR_L:   reg_rd = ptr_ext[7:0];
      R_PTR_M:   reg_rd = ptr_ext[15:8];
      R_PTR_H:   reg_rd = ptr_ext[23:16];
      R_CTRL:    reg_rd = {6'b0, ainc, win_en};
      R_ID:      reg_rd = ID_VALUE;
      default:   reg_rd = 8'h00;
    endcase
  end

  // Next bank/ptr: byte-lane writes without carry; auto-increment only on
  // DATA cycles, which never coincide with a pointer-byte write.
  always_comb begin
    bank_nxt = bank_ext;
    ptr_nxt  = ptr_ext;
    if (reg_wr) begin
      case (rsel)
        R_BANK_LO: bank_nxt[7:0]   = data_cpu;
        R_BANK_HI: bank_nxt[15:8]  = data_cpu;
        R_PTR_L:   ptr_nxt[7:0]    = data_cpu;
        R_PTR_M:   ptr_nxt[15:8]   = data_cpu;
        R_PTR_H:   ptr_nxt[23:16]  = data_cpu;
        default: ;
      endcase
    end
    if (data_sel && ainc)
      ptr_nxt = 24'(ptr + MEM_AW'(1));
  end

  // State update at the closing edge; reset restores the legacy bank-0 map.
  always_ff @(posedge clock_cpu or negedge _reset_cpu) begin
    if (!_reset_cpu) begin
      bank   <= '0;
      ptr    <= '0;
      win_en <= 1'b1;
      ainc   <= 1'b0;
    end else begin
      bank <= BW'(bank_nxt);
      ptr  <= MEM_AW'(ptr_nxt);
      if (reg_wr && rsel == R_CTRL) begin
        win_en <= data_cpu[0];
        ainc   <= data_cpu[1];
      end
    end
  end

  // SRAM address/strobes and data steering.
  always_comb begin
    bus.address_mem = io1 ? {bank, bus.address_cpu[WIN_AW-1:0]} : ptr;
    bus._ce_ram     = ~ce;
    bus._we_mem     = ce ? bus.r_w_cpu : 1'b1;
    bus._enbus      = 1'b1;
    cpu_oe          = bus.r_w_cpu & ((io1 & win_en) | io2);
    cpu_out         = (io1 | data_sel) ? data_mem : reg_rd;
    mem_oe          = ce & ~bus.r_w_cpu;
  end

  assign data_cpu = cpu_oe ? cpu_out  : 8'hzz;
  assign data_mem = mem_oe ? data_cpu : 8'hzz;

  wire unused_ok = &{1'b0, bus.address_cpu[15:8], bank_ext[23:16]};

endmodule

// File: tb/tb_io_ram_banker.sv
// Directed bench for io_ram_banker: bus cycles are launched on the falling
// edge, observed 2 time units later, and closed by the next rising edge.
module tb_io_ram_banker;

  logic clk;
  logic rst_n;
  logic [7:0] cpu_drv;
  logic       cpu_en;
  wire  [7:0] data_cpu;
  wire  [7:0] data_mem;
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sram [0:(1<<19)-1];

  io_ram_banker_if #(.MEM_AW(19)) ifc ();

  io_ram_banker #(.MEM_AW(19), .WIN_AW(8), .ID_VALUE(8'h54)) dut (
    .clock_cpu  (clk),
    ._reset_cpu (rst_n),
    .bus        (ifc.slave),
    .data_cpu   (data_cpu),
    .data_mem   (data_mem)
  );

  assign data_cpu = cpu_en ? cpu_drv : 8'hzz;
  assign data_mem = (!ifc._ce_ram && ifc._we_mem) ? sram[ifc.address_mem] : 8'hzz;

  // SRAM model latches writes at the edge that closes the cycle
  always @(posedge clk)
    if (!ifc._ce_ram && !ifc._we_mem) sram[ifc.address_mem] <= data_mem;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:1] io, input logic rw, input logic [15:0] a, input logic [7:0] wd);
    @(negedge clk);
    ifc._io = io;
    ifc.r_w_cpu = rw;
    ifc.address_cpu = a;
    cpu_drv = wd;
    cpu_en = ~rw;
    #2;
  endtask

  task automatic close();
    @(posedge clk);
    #1;
    ifc._io = 2'b11;
    ifc.r_w_cpu = 1'b1;
    cpu_en = 1'b0;
  endtask

  task automatic wr2(input logic [15:0] a, input logic [7:0] d);
    drive(2'b01, 1'b0, a, d);
    close();
  endtask

  task automatic rd2(input string tag, input logic [15:0] a, input logic [7:0] exp);
    drive(2'b01, 1'b1, a, 8'h00);
    chk(tag, {24'h0, data_cpu}, {24'h0, exp});
    close();
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_en = 1'b0;
    cpu_drv = 8'h00;
    ifc._io = 2'b11;
    ifc.r_w_cpu = 1'b1;
    ifc.address_cpu = 16'h0000;
    #12;
    chk("enbus", {31'h0, ifc._enbus}, 32'h1);
    chk("idle_ce", {31'h0, ifc._ce_ram}, 32'h1);
    rst_n = 1'b1;

    // reset state
    rd2("ctrl_rst", 16'hDF06, 8'h01);
    rd2("bank_rst", 16'hDF00, 8'h00);
    rd2("ptrh_rst", 16'hDF04, 8'h00);

    // IO1 window at bank 0
    drive(2'b10, 1'b0, 16'hDE34, 8'h5A);
    chk("io1w_addr", 32'(ifc.address_mem), 32'h00034);
    chk("io1w_ce", {31'h0, ifc._ce_ram}, 32'h0);
    chk("io1w_we", {31'h0, ifc._we_mem}, 32'h0);
    chk("io1w_dmem", {24'h0, data_mem}, 32'h5A);
    close();
    chk("sram_34", {24'h0, sram[19'h00034]}, 32'h5A);
    drive(2'b10, 1'b0, 16'hDE01, 8'hC3);
    close();
    drive(2'b10, 1'b1, 16'hDE34, 8'h00);
    chk("io1r_addr", 32'(ifc.address_mem), 32'h00034);
    chk("io1r_ce", {31'h0, ifc._ce_ram}, 32'h0);
    chk("io1r_we", {31'h0, ifc._we_mem}, 32'h1);
    chk("io1r_data", {24'h0, data_cpu}, 32'h5A);
    close();

    // bank select
    wr2(16'hDF00, 8'hA5);
    wr2(16'hDF01, 8'h07);
    drive(2'b10, 1'b1, 16'hDE10, 8'h00);
    chk("bank_addr", 32'(ifc.address_mem), 32'h7A510);
    close();
    rd2("bank_hi", 16'hDF01, 8'h07);
    rd2("bank_lo_mirror", 16'hDF08, 8'hA5);
    wr2(16'hDF01, 8'hFF);
    rd2("bank_hi_mask", 16'hDF01, 8'h07);

    // window disable / restore
    wr2(16'hDF06, 8'h00);
    drive(2'b10, 1'b1, 16'hDE34, 8'h00);
    chk("win_off_ce", {31'h0, ifc._ce_ram}, 32'h1);
    chk("win_off_we", {31'h0, ifc._we_mem}, 32'h1);
    chk("win_off_hiz", {31'h0, dut.cpu_oe}, 32'h0);
    close();
    rd2("ctrl_zero", 16'hDF06, 8'h00);
    wr2(16'hDF06, 8'h01);
    drive(2'b10, 1'b1, 16'hDE10, 8'h00);
    chk("win_on_ce", {31'h0, ifc._ce_ram}, 32'h0);
    close();

    // pointer wrap with auto-increment
    wr2(16'hDF02, 8'hFE);
    wr2(16'hDF03, 8'hFF);
    wr2(16'hDF04, 8'h07);
    wr2(16'hDF06, 8'h03);
    drive(2'b01, 1'b0, 16'hDF05, 8'h11);
    chk("dw0_addr", 32'(ifc.address_mem), 32'h7FFFE);
    chk("dw0_we", {31'h0, ifc._we_mem}, 32'h0);
    chk("dw0_dmem", {24'h0, data_mem}, 32'h11);
    close();
    drive(2'b01, 1'b0, 16'hDF05, 8'h22);
    chk("dw1_addr", 32'(ifc.address_mem), 32'h7FFFF);
    close();
    drive(2'b01, 1'b0, 16'hDF05, 8'h33);
    chk("dw2_addr", 32'(ifc.address_mem), 32'h00000);
    chk("dw2_ce", {31'h0, ifc._ce_ram}, 32'h0);
    close();
    chk("sram_7fffe", {24'h0, sram[19'h7FFFE]}, 32'h11);
    chk("sram_7ffff", {24'h0, sram[19'h7FFFF]}, 32'h22);
    chk("sram_0", {24'h0, sram[19'h00000]}, 32'h33);
    rd2("ptr_l_wrap", 16'hDF02, 8'h01);
    rd2("ptr_m_wrap", 16'hDF03, 8'h00);
    rd2("ptr_h_wrap", 16'hDF04, 8'h00);
    wr2(16'hDF04, 8'hFF);
    rd2("ptr_h_mask", 16'hDF04, 8'h07);
    wr2(16'hDF04, 8'h00);

    // DATA reads without auto-increment
    wr2(16'hDF06, 8'h01);
    drive(2'b01, 1'b1, 16'hDF05, 8'h00);
    chk("dr0_addr", 32'(ifc.address_mem), 32'h00001);
    chk("dr0_data", {24'h0, data_cpu}, 32'hC3);
    close();
    drive(2'b01, 1'b1, 16'hDF05, 8'h00);
    chk("dr1_addr", 32'(ifc.address_mem), 32'h00001);
    chk("dr1_we", {31'h0, ifc._we_mem}, 32'h1);
    close();
    rd2("ptr_l_hold", 16'hDF02, 8'h01);
    rd2("id", 16'hDF07, 8'h54);
    wr2(16'hDF07, 8'h99);
    rd2("id_ro", 16'hDF07, 8'h54);

    // asynchronous reset mid-cycle
    wr2(16'hDF00, 8'h23);
    wr2(16'hDF01, 8'h01);
    wr2(16'hDF02, 8'h67);
    wr2(16'hDF03, 8'h45);
    wr2(16'hDF06, 8'h03);
    drive(2'b01, 1'b1, 16'hDF00, 8'h00);
    chk("pre_rst_bank", {24'h0, data_cpu}, 32'h23);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_bank", {24'h0, data_cpu}, 32'h00);
    rst_n = 1'b1;
    close();
    rd2("rst_bank_hi", 16'hDF01, 8'h00);
    rd2("rst_ptr_l", 16'hDF02, 8'h00);
    rd2("rst_ptr_m", 16'hDF03, 8'h00);
    rd2("rst_ctrl", 16'hDF06, 8'h01);

    // both selects low decode as IO1 and leave registers alone
    drive(2'b00, 1'b0, 16'hDF00, 8'h55);
    chk("both_addr", 32'(ifc.address_mem), 32'h00000);
    chk("both_ce", {31'h0, ifc._ce_ram}, 32'h0);
    chk("both_we", {31'h0, ifc._we_mem}, 32'h0);
    close();
    rd2("both_bank", 16'hDF00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_ram_banker.md
Name: io_ram_banker

Overview:
- Successor to the fixed IO1-to-RAM cartridge mapper. The IO1 page ($DE00-$DEFF) still maps onto external SRAM, but through a software-selectable bank register, so the whole SRAM is reachable.
- Adds an IO2 ($DF00-$DFFF) control register file and a pointer-based data port with optional auto-increment.
- Sits between the C64 expansion bus and the cartridge SRAM. CPU address drivers stay disabled.

Parameters:
- MEM_AW, 19, SRAM address width. Legal range 12..24.
- WIN_AW, 8, IO1 window width in address bits. The window is 2^WIN_AW bytes, mirrored within IO1. Legal range 1..8.
- ID_VALUE, 8'h54, read-only identification byte at IO2 register 7.

Ports:
- clock_cpu  in  1  bus clock. Each rising edge closes one bus cycle.
- _reset_cpu  in  1  asynchronous, active-low reset.
- r_w_cpu  in  1  1 = read, 0 = write.
- _io  in  2 ([2:1])  active-low IO1/IO2 selects.
- address_cpu  in  16  CPU address.
- data_cpu  inout  8  CPU data bus.
- _enbus  out  1  CPU address buffer enable. Constant 1.
- address_mem  out  MEM_AW  SRAM address.
- data_mem  inout  8  SRAM data bus.
- _we_mem  out  1  SRAM write enable, active low.
- _ce_ram  out  1  SRAM chip enable, active low.

Behaviour:
- Bus-cycle model:
  - A cycle is "IO1" when _io[1]=0, and "IO2" when _io[2]=0 and _io[1]=1. IO1 wins if both are low.
  - Register writes and pointer increments occur on the rising clock_cpu edge that ends the cycle. All decode and data steering is combinational.
- Derived width: BW = MEM_AW - WIN_AW.
- IO2 registers, selected by address_cpu[2:0] and mirrored across the page:
  - 0 BANK_LO: bank[7:0].
  - 1 BANK_HI: bank[BW-1:8]. Unimplemented bits read 0 and ignore writes.
  - 2 PTR_L, 3 PTR_M, 4 PTR_H: ptr bits [7:0], [15:8] and [MEM_AW-1:16]. Unimplemented bits read 0.
  - 5 DATA: SRAM access at ptr.
  - 6 CTRL: bit0 WIN_EN, bit1 AINC. Other bits read 0.
  - 7 ID: reads ID_VALUE. Writes ignored.
- Reset (asynchronous, takes effect immediately, including mid-cycle):
  - bank=0, ptr=0, CTRL=8'h01 (window enabled, so power-on behaviour equals the predecessor: IO1 maps to SRAM bank 0).
  - Outputs are combinational from registers, so they follow at once.
- SRAM address mux:
  - IO1: address_mem = {bank, address_cpu[WIN_AW-1:0]}.
  - Otherwise: address_mem = ptr.
- _ce_ram = 0 iff (IO1 and WIN_EN) or (IO2 and reg=5). Otherwise 1.
- _we_mem = r_w_cpu when _ce_ram=0, else 1.
- data_cpu is driven only when r_w_cpu=1 and:
  - IO1 with WIN_EN: drive data_mem.
  - IO2 with reg=5: drive data_mem.
  - IO2 with any other reg: drive the register value.
  - Everything else, including IO1 with WIN_EN=0: high-Z.
- data_mem is driven from data_cpu only when _ce_ram=0 and r_w_cpu=0. Otherwise high-Z.
- Auto-increment:
  - Every completed IO2 reg-5 cycle (read or write) with AINC=1 increments ptr by 1 at the closing edge.
  - ptr wraps from all-ones to 0.
  - Accesses to any other register never change ptr.
  - 6502 dummy/double cycles each count. Software is responsible for avoiding them.
- Writes to PTR_x take effect at the closing edge. Only the written byte changes; no carry into other bytes.
- IO1 cycles never modify registers.

Test Plan:
- Reset, then IO1 read at $DE34 -> address_mem=19'h00034, _ce_ram=0, data_cpu=data_mem. IO1 write -> _we_mem=0.
- Write BANK_LO=$A5 and BANK_HI=$07, then IO1 at $DE10 -> address_mem=19'h7A510. Reading BANK_HI returns $07.
- Write CTRL=$00, then IO1 read -> _ce_ram=1, data_cpu high-Z. Write CTRL=$01 -> window restored.
- Write PTR=$7FFFE and CTRL=$03, then three DATA writes -> SRAM addresses $7FFFE, $7FFFF, $00000. ptr reads back $00001.
- CTRL=$01 (AINC off), two DATA reads -> both at the same ptr, ptr unchanged. ID read -> $54, and a write to ID leaves it $54.
- Mid-sequence with bank=$123 and ptr=$4567, pulse _reset_cpu low between clock edges -> bank, ptr and CTRL immediately read back 0, 0 and $01. Both _io held low -> IO1 decode, no register write.
